// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-access initiator: one command in, one cyc/stb cycle, one response out.
// A command that never sees an ack can be aborted after TIMEOUT_CYC bus cycles.
module wb_cmd_initiator #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            m_cyc_o,
  output logic            m_stb_o,
  output logic            m_we_o,
  output logic [AW-1:0]   m_adr_o,
  output logic [DW-1:0]   m_dat_o,
  output logic [DW/8-1:0] m_sel_o,
  input  logic [DW-1:0]   m_dat_i,
  input  logic            m_ack_i,
  output logic [7:0]      stray_ack
);

  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      stray_q, stray_d;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    stray_d     = stray_q;

    // Acks outside a bus cycle carry no data; they are only counted.
    if (state_q != BUS && m_ack_i && stray_q != 8'hFF) begin
      stray_d = stray_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_wdata;
          sel_d   = cmd_sel;
          cnt_d   = '0;
        end
      end
      BUS: begin
        if (m_ack_i) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          adr_d       = '0;
          dat_d       = '0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : m_dat_i;
          rsp_err_d   = 1'b0;
        end else if ((TIMEOUT_CYC > 0) && (cnt_q == CNT_LAST)) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          adr_d       = '0;
          dat_d       = '0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else if (TIMEOUT_CYC > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      stray_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      stray_q     <= stray_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign m_cyc_o   = cyc_q;
  assign m_stb_o   = cyc_q;
  assign m_we_o    = we_q;
  assign m_adr_o   = adr_q;
  assign m_dat_o   = dat_q;
  assign m_sel_o   = sel_q;
  assign stray_ack = stray_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator: writes, waited reads, timeout, response backpressure,
// stray acks and reset during a bus cycle, each checked against hand-computed values.
module tb_wb_cmd_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_ack_i;
  logic [7:0]  stray_ack;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  wb_cmd_initiator #(.AW(32), .DW(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .stray_ack(stray_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_wdata = wd; cmd_sel = sel;
    tick();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_wdata = '0; cmd_sel = '0;
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_wdata = '0;
    cmd_sel = '0; rsp_ready = 1'b0; m_dat_i = '0; m_ack_i = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cyc", {m_cyc_o, m_stb_o, m_we_o}, 0);
    chk("rst_bus", {m_adr_o, m_dat_o[27:0], m_sel_o}, 0);
    chk("rst_stray", stray_ack, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // 1: write, zero-wait ack
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    chk("t1_cyc_stb", {m_cyc_o, m_stb_o, m_we_o}, 3'b111);
    chk("t1_adr", m_adr_o, 32'h10);
    chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
    chk("t1_sel", m_sel_o, 4'hF);
    chk("t1_busy", {cmd_ready, rsp_valid}, 2'b00);
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    chk("t1_cyc_drop", {m_cyc_o, m_stb_o, m_we_o}, 0);
    chk("t1_bus_clear", m_adr_o, 0);
    chk("t1_rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("t1_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_done", {rsp_valid, cmd_ready}, 2'b01);

    // 2 + 4: read with three wait states, then response held for 5 cycles
    m_dat_i = 32'h1234_5678;
    send(1'b0, 32'h0000_0004, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait_bus", {m_cyc_o, m_stb_o, m_we_o, m_adr_o}, {3'b110, 32'h4});
      tick();
    end
    chk("t2_4th_bus", {m_cyc_o, m_stb_o, m_we_o, m_adr_o}, {3'b110, 32'h4});
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0; m_dat_i = 32'hFFFF_FFFF;
    chk("t2_rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("t2_rdata", rsp_rdata, 32'h1234_5678);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h80;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold", {rsp_valid, rsp_rdata, cmd_ready, m_cyc_o}, {1'b1, 32'h1234_5678, 2'b00});
    end
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t4_release", {rsp_valid, cmd_ready, m_cyc_o}, 3'b010);

    // 3: timeout after exactly 8 bus cycles
    send(1'b0, 32'h0000_0020, 32'h0, 4'h3);
    n = 0;
    while (m_cyc_o && n < 20) begin
      n++;
      tick();
    end
    chk("t3_cyc_cycles", n, 8);
    chk("t3_rsp", {rsp_valid, rsp_err, m_stb_o}, 3'b110);
    chk("t3_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t3_ready_again", cmd_ready, 1);
    send(1'b1, 32'h0000_0024, 32'h5555_AAAA, 4'h1);
    chk("t3_next_accepted", {m_cyc_o, m_we_o, m_dat_o}, {2'b11, 32'h5555_AAAA});
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    chk("t3_next_rsp", {rsp_valid, rsp_err}, 2'b10);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ack arriving on the very cycle the timeout would expire wins
    m_dat_i = 32'hCAFE_0001;
    send(1'b0, 32'h0000_0028, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) tick();
    chk("tie_still_bus", m_cyc_o, 1);
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    chk("tie_rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("tie_rdata", rsp_rdata, 32'hCAFE_0001);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 5: 300 stray acks in IDLE saturate the counter
    for (int i = 0; i < 300; i++) begin
      m_ack_i = 1'b1;
      tick();
      m_ack_i = 1'b0;
      tick();
      if (i == 9) chk("t5_stray10", stray_ack, 10);
    end
    chk("t5_stray_sat", stray_ack, 255);
    chk("t5_no_rsp", {rsp_valid, cmd_ready, m_cyc_o}, 3'b010);
    m_dat_i = 32'hA5A5_0F0F;
    send(1'b0, 32'h0000_0030, 32'h0, 4'hF);
    tick();
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    chk("t5_read_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hA5A5_0F0F});
    chk("t5_stray_held", stray_ack, 255);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 6: reset during a waited bus cycle
    send(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    tick();
    chk("t6_in_bus", {m_cyc_o, m_stb_o}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("t6_async_drop", {m_cyc_o, m_stb_o, cmd_ready}, 3'b000);
    m_ack_i = 1'b1;
    tick(); tick();
    m_ack_i = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("t6_after_release", {cmd_ready, rsp_valid, m_cyc_o}, 3'b100);
    chk("t6_stray_cleared", stray_ack, 0);
    tick(); tick();
    chk("t6_no_stale_rsp", {rsp_valid, m_cyc_o, rsp_rdata}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
